// File: rtl/elixirchip_es1_spu_op_mem_arb_pkg.sv
// Shared types for the two-requester scratch-RAM arbiter.
// A read tag records which requester is waiting for the data.
package elixirchip_es1_spu_op_mem_arb_pkg;

   localparam int NUM_REQ = 2;

   typedef logic [0:0] req_id_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
   } tag_t;

endpackage

// File: rtl/elixirchip_es1_spu_op_mem_arb_tag_pipe.sv
// Read-tag delay line that matches the memory read latency. It shifts only
// on cke cycles, and reset drops every in-flight tag.
module elixirchip_es1_spu_op_mem_arb_tag_pipe
   import elixirchip_es1_spu_op_mem_arb_pkg::*;
#(
   parameter int LATENCY = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic cke,
   input  logic in_valid,
   input  logic in_id,
   output logic out_valid,
   output logic out_id
);

   tag_t stage_p [LATENCY];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < LATENCY; i++) stage_p[i] <= '0;
      end else if (cke) begin
         stage_p[0] <= '{valid: in_valid, id: in_id};
         for (int i = 1; i < LATENCY; i++) stage_p[i] <= stage_p[i-1];
      end
   end

   assign out_valid = stage_p[LATENCY-1].valid;
   assign out_id    = stage_p[LATENCY-1].id;

endmodule

// File: rtl/elixirchip_es1_spu_op_mem_sp.sv
// Single-port scratch RAM. The read is registered, and the data is then
// delayed so that it appears LATENCY cke cycles after the address.
module elixirchip_es1_spu_op_mem_sp #(
   parameter int LATENCY    = 3,
   parameter int DATA_BITS  = 8,
   parameter int ADDR_BITS  = 3,
   parameter     DEVICE     = "RTL",
   parameter     SIMULATION = "false"
) (
   input  logic                 clk,
   input  logic                 cke,
   input  logic [ADDR_BITS-1:0] s_addr,
   input  logic [DATA_BITS-1:0] s_wdata,
   input  logic                 s_wvalid,
   output logic [DATA_BITS-1:0] m_rdata
);

   localparam int DEPTH    = 1 << ADDR_BITS;
   // The simulation model always uses the plain array, even when the target is UltraRAM.
   localparam bit USE_URAM = (DEVICE == "ULTRASCALE_PLUS") && (SIMULATION != "true");

   logic [DATA_BITS-1:0] ram_p0;

   if (USE_URAM) begin : g_uram
      (* ram_style = "ultra" *) logic [DATA_BITS-1:0] mem [DEPTH];
      always_ff @(posedge clk) begin
         if (cke) begin
            if (s_wvalid) mem[s_addr] <= s_wdata;
            ram_p0 <= mem[s_addr];
         end
      end
   end else begin : g_rtl
      logic [DATA_BITS-1:0] mem [DEPTH];
      always_ff @(posedge clk) begin
         if (cke) begin
            if (s_wvalid) mem[s_addr] <= s_wdata;
            ram_p0 <= mem[s_addr];
         end
      end
   end

   // Stages after the RAM output register
   if (LATENCY > 1) begin : g_dly
      logic [DATA_BITS-1:0] dly_p [LATENCY-1];
      always_ff @(posedge clk) begin
         if (cke) begin
            dly_p[0] <= ram_p0;
            for (int i = 1; i < LATENCY - 1; i++) dly_p[i] <= dly_p[i-1];
         end
      end
      assign m_rdata = dly_p[LATENCY-2];
   end else begin : g_nodly
      assign m_rdata = ram_p0;
   end

endmodule

// File: rtl/elixirchip_es1_spu_op_mem_sp_arb2.sv
// Round-robin arbiter that lets two SPU op lanes share one single-port scratch RAM.
// Each read result is returned to the lane that issued the read.
module elixirchip_es1_spu_op_mem_sp_arb2
   import elixirchip_es1_spu_op_mem_arb_pkg::*;
#(
   parameter int LATENCY    = 3,
   parameter int DATA_BITS  = 8,
   parameter int ADDR_BITS  = 3,
   parameter     DEVICE     = "RTL",
   parameter     SIMULATION = "false",
   parameter     DEBUG      = "false"
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cke,
   input  logic [ADDR_BITS-1:0] s0_addr,
   input  logic [DATA_BITS-1:0] s0_wdata,
   input  logic                 s0_we,
   input  logic                 s0_valid,
   output logic                 s0_ready,
   input  logic [ADDR_BITS-1:0] s1_addr,
   input  logic [DATA_BITS-1:0] s1_wdata,
   input  logic                 s1_we,
   input  logic                 s1_valid,
   output logic                 s1_ready,
   output logic [DATA_BITS-1:0] m0_rdata,
   output logic                 m0_valid,
   output logic [DATA_BITS-1:0] m1_rdata,
   output logic                 m1_valid,
   output logic [31:0]          dbg_grant0,
   output logic [31:0]          dbg_grant1
);

   req_id_t              last_grant;
   req_id_t              winner;
   logic [NUM_REQ-1:0]   grant;
   logic                 accept;
   logic                 win_we;
   logic [ADDR_BITS-1:0] win_addr, hold_addr, mem_addr;
   logic [DATA_BITS-1:0] win_wdata, hold_wdata, mem_wdata, mem_rdata;
   logic                 tail_valid;
   logic                 tail_id;

   always_comb begin
      winner = 1'b0;
      if (s0_valid && s1_valid) winner = ~last_grant;
      else if (s1_valid)        winner = 1'b1;
   end

   assign accept    = cke && (s0_valid || s1_valid);
   assign grant[0]  = accept && (winner == 1'b0);
   assign grant[1]  = accept && (winner == 1'b1);
   assign s0_ready  = grant[0];
   assign s1_ready  = grant[1];

   assign win_addr  = winner[0] ? s1_addr  : s0_addr;
   assign win_wdata = winner[0] ? s1_wdata : s0_wdata;
   assign win_we    = winner[0] ? s1_we    : s0_we;

   // When there is no access, the RAM sees the last granted address, which gives it a harmless dummy read.
   assign mem_addr  = accept ? win_addr  : hold_addr;
   assign mem_wdata = accept ? win_wdata : hold_wdata;

   always_ff @(posedge clk) begin
      if (reset)       last_grant <= 1'b1;
      else if (accept) last_grant <= winner;
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         hold_addr  <= win_addr;
         hold_wdata <= win_wdata;
      end
   end

   elixirchip_es1_spu_op_mem_sp #(
      .LATENCY    (LATENCY),
      .DATA_BITS  (DATA_BITS),
      .ADDR_BITS  (ADDR_BITS),
      .DEVICE     (DEVICE),
      .SIMULATION (SIMULATION)
   ) u_mem (
      .clk      (clk),
      .cke      (cke),
      .s_addr   (mem_addr),
      .s_wdata  (mem_wdata),
      .s_wvalid (accept && win_we),
      .m_rdata  (mem_rdata)
   );

   elixirchip_es1_spu_op_mem_arb_tag_pipe #(
      .LATENCY (LATENCY)
   ) u_tag_pipe (
      .clk       (clk),
      .reset     (reset),
      .cke       (cke),
      .in_valid  (accept && !win_we),
      .in_id     (winner[0]),
      .out_valid (tail_valid),
      .out_id    (tail_id)
   );

   // Results travel on a shared data bus; the valid signal tells the two lanes apart.
   assign m0_valid = cke && !reset && tail_valid && (tail_id == 1'b0);
   assign m1_valid = cke && !reset && tail_valid && (tail_id == 1'b1);
   assign m0_rdata = mem_rdata;
   assign m1_rdata = mem_rdata;

   if (DEBUG == "true") begin : g_dbg
      logic [31:0] cnt0, cnt1;
      always_ff @(posedge clk) begin
         if (reset) begin
            cnt0 <= '0;
            cnt1 <= '0;
         end else begin
            if (grant[0]) cnt0 <= cnt0 + 32'd1;
            if (grant[1]) cnt1 <= cnt1 + 32'd1;
         end
      end
      assign dbg_grant0 = cnt0;
      assign dbg_grant1 = cnt1;
   end else begin : g_no_dbg
      assign dbg_grant0 = '0;
      assign dbg_grant1 = '0;
   end

endmodule

// File: tb/tb_elixirchip_es1_spu_op_mem_sp_arb2.sv
// Bench for the two-requester scratch-RAM arbiter: a transaction-level model checked on every cycle,
// plus directed scenarios with hand-computed grant and return expectations.
module tb_elixirchip_es1_spu_op_mem_sp_arb2;

   logic       clk = 1'b0;
   logic       reset, cke;
   logic [2:0] s0_addr, s1_addr;
   logic [7:0] s0_wdata, s1_wdata;
   logic       s0_we, s1_we, s0_valid, s1_valid;
   logic       s0_ready, s1_ready;
   logic [7:0] m0_rdata, m1_rdata;
   logic       m0_valid, m1_valid;
   logic [31:0] dbg_grant0, dbg_grant1;

   int checks = 0;
   int failures = 0;

   elixirchip_es1_spu_op_mem_sp_arb2 #(
      .LATENCY(3), .DATA_BITS(8), .ADDR_BITS(3),
      .DEVICE("RTL"), .SIMULATION("true"), .DEBUG("true")
   ) dut (
      .clk(clk), .reset(reset), .cke(cke),
      .s0_addr(s0_addr), .s0_wdata(s0_wdata), .s0_we(s0_we), .s0_valid(s0_valid), .s0_ready(s0_ready),
      .s1_addr(s1_addr), .s1_wdata(s1_wdata), .s1_we(s1_we), .s1_valid(s1_valid), .s1_ready(s1_ready),
      .m0_rdata(m0_rdata), .m0_valid(m0_valid), .m1_rdata(m1_rdata), .m1_valid(m1_valid),
      .dbg_grant0(dbg_grant0), .dbg_grant1(dbg_grant1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct { int cyc; int id; logic [7:0] data; } ev_t;
   typedef struct { int due; int id; logic [7:0] data; } pend_t;

   ev_t   gnt_log[$];
   ev_t   ret_log[$];
   pend_t pend[$];
   logic [7:0] m_mem [8];
   int m_last = 1;
   int m_ckecnt = 0;
   int m_cnt0 = 0, m_cnt1 = 0;
   int cyc = 0;

   always @(negedge clk) begin
      int   g;
      logic e_v0, e_v1;
      logic [7:0] e_d;
      g = -1;
      if (cke) begin
         if (s0_valid && s1_valid) g = (m_last == 0) ? 1 : 0;
         else if (s0_valid)        g = 0;
         else if (s1_valid)        g = 1;
      end
      chk("s0_ready", {31'd0, s0_ready}, {31'd0, g == 0});
      chk("s1_ready", {31'd0, s1_ready}, {31'd0, g == 1});

      e_v0 = 1'b0; e_v1 = 1'b0; e_d = '0;
      if (cke && !reset)
         foreach (pend[i])
            if (pend[i].due == m_ckecnt) begin
               if (pend[i].id == 0) e_v0 = 1'b1; else e_v1 = 1'b1;
               e_d = pend[i].data;
            end
      chk("m0_valid", {31'd0, m0_valid}, {31'd0, e_v0});
      chk("m1_valid", {31'd0, m1_valid}, {31'd0, e_v1});
      if (e_v0) chk("m0_rdata", {24'd0, m0_rdata}, {24'd0, e_d});
      if (e_v1) chk("m1_rdata", {24'd0, m1_rdata}, {24'd0, e_d});
      chk("dbg_grant0", dbg_grant0, m_cnt0);
      chk("dbg_grant1", dbg_grant1, m_cnt1);

      if (s0_ready) gnt_log.push_back('{cyc, 0, 8'h00});
      if (s1_ready) gnt_log.push_back('{cyc, 1, 8'h00});
      if (m0_valid) ret_log.push_back('{cyc, 0, m0_rdata});
      if (m1_valid) ret_log.push_back('{cyc, 1, m1_rdata});

      if (g >= 0) begin
         logic we; logic [2:0] a; logic [7:0] d;
         we = (g == 0) ? s0_we : s1_we;
         a  = (g == 0) ? s0_addr : s1_addr;
         d  = (g == 0) ? s0_wdata : s1_wdata;
         if (we) m_mem[a] = d;
         else    pend.push_back('{m_ckecnt + 3, g, m_mem[a]});
         m_last = g;
         if (g == 0) m_cnt0++; else m_cnt1++;
      end
      if (cke) m_ckecnt++;
      while (pend.size() > 0 && pend[0].due < m_ckecnt) void'(pend.pop_front());
      if (reset) begin
         pend.delete();
         m_last = 1;
         m_cnt0 = 0;
         m_cnt1 = 0;
      end
      cyc++;
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_logs();
      gnt_log.delete();
      ret_log.delete();
   endtask

   // Present both requests and hold each one until it is granted.
   task automatic do_req(input logic v0, input logic we0, input logic [2:0] a0, input logic [7:0] d0,
                         input logic v1, input logic we1, input logic [2:0] a1, input logic [7:0] d1);
      logic p0, p1;
      int n;
      p0 = v0; p1 = v1; n = 0;
      s0_we = we0; s0_addr = a0; s0_wdata = d0;
      s1_we = we1; s1_addr = a1; s1_wdata = d1;
      while ((p0 || p1) && n < 20) begin
         s0_valid = p0;
         s1_valid = p1;
         #3;
         if (s0_ready) p0 = 1'b0;
         if (s1_ready) p1 = 1'b0;
         @(posedge clk);
         #1;
         n++;
      end
      s0_valid = 1'b0;
      s1_valid = 1'b0;
      checks++;
      if (p0 || p1) begin
         failures++;
         $display("FAIL req_timeout: pending s0=%0d s1=%0d expected none", p0, p1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; cke = 1'b1;
      s0_addr = '0; s1_addr = '0; s0_wdata = '0; s1_wdata = '0;
      s0_we = 1'b0; s1_we = 1'b0; s0_valid = 1'b0; s1_valid = 1'b0;
      step(2);
      reset = 1'b0;
      chk("rst_m0_valid", {31'd0, m0_valid}, 32'd0);
      chk("rst_m1_valid", {31'd0, m1_valid}, 32'd0);
      chk("rst_dbg0", dbg_grant0, 32'd0);

      // 1: s0 writes 0x10..0x17 to addresses 0..7, one per cycle
      clear_logs();
      for (int i = 0; i < 8; i++) do_req(1'b1, 1'b1, 3'(i), 8'(8'h10 + i), 1'b0, 1'b0, 3'd0, 8'd0);
      step(5);
      chk("t1_grants", gnt_log.size(), 32'd8);
      if (gnt_log.size() == 8) begin
         chk("t1_back_to_back", gnt_log[7].cyc - gnt_log[0].cyc, 32'd7);
         foreach (gnt_log[i]) chk("t1_grant_id", gnt_log[i].id, 32'd0);
      end
      chk("t1_no_returns", ret_log.size(), 32'd0);
      chk("t1_dbg0", dbg_grant0, 32'd8);
      reset = 1'b1;
      step(1);
      reset = 1'b0;

      // 2: simultaneous reads, s0 wins the first tie after reset
      clear_logs();
      do_req(1'b1, 1'b0, 3'd2, 8'd0, 1'b1, 1'b0, 3'd5, 8'd0);
      step(6);
      chk("t2_grants", gnt_log.size(), 32'd2);
      chk("t2_returns", ret_log.size(), 32'd2);
      if (gnt_log.size() == 2 && ret_log.size() == 2) begin
         chk("t2_first_id", gnt_log[0].id, 32'd0);
         chk("t2_second_cyc", gnt_log[1].cyc - gnt_log[0].cyc, 32'd1);
         chk("t2_ret0_cyc", ret_log[0].cyc - gnt_log[0].cyc, 32'd3);
         chk("t2_ret0_id", ret_log[0].id, 32'd0);
         chk("t2_ret0_data", {24'd0, ret_log[0].data}, 32'h12);
         chk("t2_ret1_cyc", ret_log[1].cyc - gnt_log[0].cyc, 32'd4);
         chk("t2_ret1_id", ret_log[1].id, 32'd1);
         chk("t2_ret1_data", {24'd0, ret_log[1].data}, 32'h15);
      end

      // 3: both requesters reading continuously for 8 cycles
      clear_logs();
      s0_we = 1'b0; s1_we = 1'b0; s0_addr = 3'd1; s1_addr = 3'd6;
      s0_valid = 1'b1; s1_valid = 1'b1;
      step(8);
      s0_valid = 1'b0; s1_valid = 1'b0;
      step(6);
      chk("t3_grants", gnt_log.size(), 32'd8);
      chk("t3_returns", ret_log.size(), 32'd8);
      if (gnt_log.size() == 8 && ret_log.size() == 8) begin
         foreach (gnt_log[i]) chk("t3_alternate", gnt_log[i].id, 32'(i % 2));
         foreach (ret_log[i])
            chk("t3_ret_data", {24'd0, ret_log[i].data}, (i % 2 == 0) ? 32'h11 : 32'h16);
      end

      // 4: write then read at the same address, with one cke=0 cycle in flight
      clear_logs();
      do_req(1'b0, 1'b0, 3'd0, 8'd0, 1'b1, 1'b1, 3'd5, 8'hAA);
      s1_we = 1'b0; s1_addr = 3'd5; s1_valid = 1'b1;
      step(1);
      s1_valid = 1'b0;
      step(1);
      cke = 1'b0;
      step(1);
      cke = 1'b1;
      step(5);
      chk("t4_grants", gnt_log.size(), 32'd2);
      chk("t4_returns", ret_log.size(), 32'd1);
      if (gnt_log.size() == 2 && ret_log.size() == 1) begin
         chk("t4_read_id", gnt_log[1].id, 32'd1);
         chk("t4_ret_cyc", ret_log[0].cyc - gnt_log[1].cyc, 32'd4);
         chk("t4_ret_id", ret_log[0].id, 32'd1);
         chk("t4_ret_data", {24'd0, ret_log[0].data}, 32'hAA);
      end

      // 5: reset while three reads are in flight
      clear_logs();
      for (int i = 0; i < 3; i++) do_req(1'b1, 1'b0, 3'(i), 8'd0, 1'b0, 1'b0, 3'd0, 8'd0);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      step(5);
      chk("t5_dropped", ret_log.size(), 32'd0);
      clear_logs();
      do_req(1'b1, 1'b0, 3'd4, 8'd0, 1'b1, 1'b0, 3'd7, 8'd0);
      step(6);
      chk("t5_tie_grants", gnt_log.size(), 32'd2);
      if (gnt_log.size() == 2) chk("t5_tie_first", gnt_log[0].id, 32'd0);
      chk("t5_returns", ret_log.size(), 32'd2);
      if (ret_log.size() == 2) begin
         chk("t5_ret0_data", {24'd0, ret_log[0].data}, 32'h14);
         chk("t5_ret1_data", {24'd0, ret_log[1].data}, 32'h17);
      end

      // 6: a request while cke=0 must not be granted or reach the memory
      clear_logs();
      cke = 1'b0;
      s0_we = 1'b1; s0_addr = 3'd3; s0_wdata = 8'h55; s0_valid = 1'b1;
      #3;
      chk("t6_ready_low", {31'd0, s0_ready}, 32'd0);
      step(3);
      s0_valid = 1'b0;
      cke = 1'b1;
      chk("t6_no_grant", gnt_log.size(), 32'd0);
      do_req(1'b1, 1'b0, 3'd3, 8'd0, 1'b0, 1'b0, 3'd0, 8'd0);
      step(5);
      chk("t6_returns", ret_log.size(), 32'd1);
      if (ret_log.size() == 1) chk("t6_mem_unchanged", {24'd0, ret_log[0].data}, 32'h13);
      chk("end_dbg0", dbg_grant0, 32'd2);
      chk("end_dbg1", dbg_grant1, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
